// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared types and select constants for the round-robin mux arbiter
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_e;

  // sel 0 picks the first mux input, matching the static 2:1 mux this block replaces
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  function automatic arb_state_e own_state(input logic sel);
    return (sel == SEL_B) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester, output and status signals of the round-robin mux arbiter
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 2
);

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;
  logic             busy;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel, busy
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel, busy
  );

endinterface

// File: rtl/mux_arb_out_stage.sv
// rtl/mux_arb_out_stage.sv - single-entry valid/ready output register for the arbiter
module mux_arb_out_stage #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_accept,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             can_accept
);

  // A new beat may land when the slot is empty or is being drained this cycle
  assign can_accept = out_ready | ~out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (in_accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_sel   <= in_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin ownership FSM sharing one registered 2:1 select path
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_rr_arbiter_if.slave bus
);

  localparam int             CW     = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CAP_M1 = CW'(MAX_BURST - 1);

  arb_state_e       state, next_state;
  logic             last, next_last;
  logic [CW-1:0]    count, next_count;

  logic             owning;
  logic             own_sel;
  logic             own_valid;
  logic             oth_valid;
  logic             can_accept;
  logic             accept;
  logic             cap_hit;
  logic [WIDTH-1:0] sel_data;

  assign owning    = (state != IDLE);
  assign own_sel   = (state == OWN_B) ? SEL_B : SEL_A;
  assign own_valid = (own_sel == SEL_B) ? bus.b_valid : bus.a_valid;
  assign oth_valid = (own_sel == SEL_B) ? bus.a_valid : bus.b_valid;

  // Ready depends only on state and output occupancy, never on the requester valids
  assign bus.a_ready = (state == OWN_A) & can_accept;
  assign bus.b_ready = (state == OWN_B) & can_accept;
  assign bus.busy    = owning;

  assign accept   = owning & own_valid & can_accept;
  assign cap_hit  = accept & (count == CAP_M1);
  assign sel_data = (own_sel == SEL_B) ? bus.b_data : bus.a_data;

  always_comb begin
    next_state = state;
    next_last  = last;
    next_count = count;
    case (state)
      IDLE: begin
        next_count = '0;
        if (bus.a_valid && bus.b_valid) begin
          next_state = own_state(~last);
        end else if (bus.a_valid) begin
          next_state = OWN_A;
        end else if (bus.b_valid) begin
          next_state = OWN_B;
        end
      end
      OWN_A, OWN_B: begin
        // Release on an idle owner or on the beat that fills the burst
        if (!own_valid || cap_hit) begin
          next_last  = own_sel;
          next_count = '0;
          if (oth_valid) begin
            next_state = own_state(~own_sel);
          end else if (own_valid) begin
            next_state = state;
          end else begin
            next_state = IDLE;
          end
        end else if (accept) begin
          next_count = count + CW'(1);
        end
      end
      default: begin
        next_state = IDLE;
        next_count = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= SEL_B;
      count <= '0;
    end else begin
      state <= next_state;
      last  <= next_last;
      count <= next_count;
    end
  end

  mux_arb_out_stage #(
    .WIDTH(WIDTH)
  ) u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_accept (accept),
    .in_data   (sel_data),
    .in_sel    (own_sel),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .out_sel   (bus.out_sel),
    .can_accept(can_accept)
  );

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit 2:1 select path between two valid/ready requesters (A and B) and drives a registered output stage. It generates the mux select from a three-state ownership FSM, bounds each ownership burst to MAX_BURST beats, and alternates owners fairly when both request. It sits directly upstream of any consumer that previously took a statically selected 2:1 mux output.

## Interface
- WIDTH, 2, data width of each requester and the output
- MAX_BURST, 4, max beats per ownership before forced re-arbitration (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a beat
- a_data  in  WIDTH  requester A beat
- a_ready  out  1  A beat accepted this cycle when a_valid & a_ready
- b_valid  in  1  requester B has a beat
- b_data  in  WIDTH  requester B beat
- b_ready  out  1  B beat accepted this cycle when b_valid & b_ready
- out_valid  out  1  out_data holds an unconsumed beat
- out_data  out  WIDTH  registered selected beat
- out_sel  out  1  source of out_data (0 = A, 1 = B)
- out_ready  in  1  consumer takes beat when out_valid & out_ready
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, OWN_A, OWN_B; registered last-owner pointer `last` (reset = B, so A wins first tie).
- IDLE: if only one valid, go to that owner; both valid, go to owner ≠ last; none, stay. No beat accepted in IDLE.
- OWN_x: x_ready = (out_ready | ~out_valid); other ready = 0. Accepted beat increments burst count (reset to 0 on entering any OWN state).
- Release from OWN_x when x_valid = 0, or when an accepted beat makes count = MAX_BURST. On release: last ← x; if other valid, go directly to OWN_other; else if x_valid still high (burst cap), re-enter OWN_x with count 0; else IDLE.
- Output stage: on accept, out_data ← x_data, out_sel ← x, out_valid ← 1. Without accept, out_valid cleared when out_ready. Accept and consume in same cycle: new beat replaces old, out_valid stays 1.
- Requester dropping valid mid-burst is a release, not an error; ownership is never held with owner idle.
- Burst counter width = clog2(MAX_BURST+1); no wrap possible since it resets at MAX_BURST.

## Timing
- Reset (async assert, sync-released use): state IDLE, last = B, count 0, out_valid 0, out_data 0, out_sel 0, a_ready 0, b_ready 0, busy 0.
- Latency from IDLE: valid at cycle 0 → OWN at cycle 1 (ready high) → out_valid at cycle 2.
- Owner switch on release costs no idle cycle; throughput 1 beat/cycle with out_ready held high, including across switches.
- Backpressure: out_ready low with out_valid high → owner ready low, count and state frozen (except release by valid drop).
- Ready is combinational from state and output-stage occupancy only; never from a_valid/b_valid (no combinational valid→ready path).
- Reset asserted mid-burst: all state cleared immediately; in-flight out_data discarded.

## Structure
- Package mux_arb_pkg: state enum (IDLE, OWN_A, OWN_B), select constants SEL_A = 1'b0, SEL_B = 1'b1 (matching the mux convention of sel 0 → first input).
- One sub-module: mux_arb_out_stage (WIDTH-wide valid/ready register holding out_data, out_sel, out_valid; exposes can_accept = out_ready | ~out_valid).
- Top holds FSM, pointer, burst counter, and the select mux.

## Test plan
- Reset: hold rst_n low with a_valid = b_valid = 1 → all outputs 0, busy 0; release → OWN_A cycle 1, out_sel 0 at cycle 2.
- Single requester: A streams 6 beats 01,10,11,00,01,10, B idle, out_ready = 1 → all 6 out in order, out_sel 0, re-entry after 4th beat with no gap.
- Contention: A and B both continuously valid, A data 01, B data 10 → out sequence 4×01, 4×10, 4×01, no idle cycles.
- Early release: A valid for 2 beats then drops, B valid → after 2 A beats, B owns next cycle, last = A.
- Backpressure: out_ready low for 3 cycles mid-burst → out_data stable, a_ready 0, count unchanged; resumes with no loss or duplication.
- Reset mid-burst: assert rst_n low during OWN_B at count 2 → out_valid 0 immediately; after release A wins first tie.
